// File: rtl/axi_full_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi_full_mem_slave
// Brief   : AXI4-full slave memory with FIXED/INCR/WRAP bursts, WSTRB byte
//           enables, ID echo and SLVERR on out-of-range or malformed beats.
// Rev     : 1.0  initial release
// ============================================================================
module axi_full_mem_slave #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 1,
    parameter int DEPTH      = 1024,
    parameter int INIT_INDEX = 1
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     axifull_AWID,
    input  logic [ADDR_W-1:0]   axifull_AWADDR,
    input  logic [7:0]          axifull_AWLEN,
    input  logic [2:0]          axifull_AWSIZE,
    input  logic [1:0]          axifull_AWBURST,
    input  logic                axifull_AWVALID,
    output logic                axifull_AWREADY,
    input  logic [DATA_W-1:0]   axifull_WDATA,
    input  logic [DATA_W/8-1:0] axifull_WSTRB,
    input  logic                axifull_WLAST,
    input  logic                axifull_WVALID,
    output logic                axifull_WREADY,
    output logic [ID_W-1:0]     axifull_BID,
    output logic [1:0]          axifull_BRESP,
    output logic                axifull_BVALID,
    input  logic                axifull_BREADY,
    input  logic [ID_W-1:0]     axifull_ARID,
    input  logic [ADDR_W-1:0]   axifull_ARADDR,
    input  logic [7:0]          axifull_ARLEN,
    input  logic [2:0]          axifull_ARSIZE,
    input  logic [1:0]          axifull_ARBURST,
    input  logic                axifull_ARVALID,
    output logic                axifull_ARREADY,
    output logic [ID_W-1:0]     axifull_RID,
    output logic [DATA_W-1:0]   axifull_RDATA,
    output logic [1:0]          axifull_RRESP,
    output logic                axifull_RLAST,
    output logic                axifull_RVALID,
    input  logic                axifull_RREADY
);

    localparam int              STRB_W      = DATA_W / 8;
    localparam int              BYTE_SH     = $clog2(STRB_W);
    localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      MAX_SIZE    = 3'(BYTE_SH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [1:0]      BURST_FIXED = 2'b00;
    localparam logic [1:0]      BURST_WRAP  = 2'b10;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0]        len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] wmask;
        step  = ADDR_ONE << size;
        incr  = (addr & ~(step - ADDR_ONE)) + step;
        wmask = ((ADDR_W'(len) + ADDR_ONE) << size) - ADDR_ONE;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
            default:     next_addr = incr;
        endcase
    endfunction

    // Reserved burst type 2'b11 is treated like any other malformed burst.
    function automatic logic burst_bad(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_bad   = (size > MAX_SIZE) || (burst == 2'b11) ||
                      ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        out_of_range = (addr >> BYTE_SH) >= ADDR_W'(DEPTH);
    endfunction

    // ------------------------------------------------------------------
    // Storage: one register per word so each can carry its power-up value.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_rd [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] word_q = (INIT_INDEX != 0) ? DATA_W'(gi) : {DATA_W{1'bx}};
        always_ff @(posedge ACLK) begin
            if (mem_we && (mem_widx == IDX_W'(gi))) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (mem_wstrb[b]) begin
                        word_q[8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end
        end
        assign mem_rd[gi] = word_q;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t           w_state_q,  w_state_d;
    logic              awready_q,  awready_d;
    logic              wready_q,   wready_d;
    logic              bvalid_q,   bvalid_d;
    logic [ID_W-1:0]   bid_q,      bid_d;
    logic [1:0]        bresp_q,    bresp_d;
    logic [ID_W-1:0]   aw_id_q,    aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q,  aw_addr_d;
    logic [7:0]        aw_len_q,   aw_len_d;
    logic [2:0]        aw_size_q,  aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic [8:0]        w_cnt_q,    w_cnt_d;
    logic              w_err_q,    w_err_d;
    logic              w_beat_bad;

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        // Beats past LEN are dropped just like out-of-range ones.
        w_beat_bad = burst_bad(aw_len_q, aw_size_q, aw_burst_q) || out_of_range(aw_addr_q) ||
                     (w_cnt_q > {1'b0, aw_len_q});
        mem_we     = 1'b0;
        mem_widx   = aw_addr_q[BYTE_SH +: IDX_W];
        mem_wdata  = axifull_WDATA;
        mem_wstrb  = axifull_WSTRB;

        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axifull_AWVALID && awready_q) begin
                    aw_id_d    = axifull_AWID;
                    aw_addr_d  = axifull_AWADDR;
                    aw_len_d   = axifull_AWLEN;
                    aw_size_d  = axifull_AWSIZE;
                    aw_burst_d = axifull_AWBURST;
                    w_cnt_d    = '0;
                    w_err_d    = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (axifull_WVALID && wready_q) begin
                    mem_we    = !w_beat_bad;
                    aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                    if (w_cnt_q != 9'h1FF) begin
                        w_cnt_d = w_cnt_q + 9'd1;
                    end
                    w_err_d = w_err_q || w_beat_bad ||
                              (axifull_WLAST && (w_cnt_q != {1'b0, aw_len_q}));
                    if (axifull_WLAST) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = aw_id_q;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axifull_BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel: ar_addr_q always holds the address of the next beat.
    // ------------------------------------------------------------------
    rstate_t           r_state_q,  r_state_d;
    logic              arready_q,  arready_d;
    logic              rvalid_q,   rvalid_d;
    logic [ID_W-1:0]   rid_q,      rid_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [1:0]        rresp_q,    rresp_d;
    logic              rlast_q,    rlast_d;
    logic [ADDR_W-1:0] ar_addr_q,  ar_addr_d;
    logic [7:0]        ar_len_q,   ar_len_d;
    logic [2:0]        ar_size_q,  ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [7:0]        r_cnt_q,    r_cnt_d;

    logic              ld_fresh;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_len;
    logic [2:0]        ld_size;
    logic [1:0]        ld_burst;
    logic              ld_last;
    logic              ld_bad;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        r_state_d  = r_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;

        // The first beat is loaded straight from the AR channel.
        ld_fresh = (r_state_q == R_IDLE);
        ld_addr  = ld_fresh ? axifull_ARADDR  : ar_addr_q;
        ld_len   = ld_fresh ? axifull_ARLEN   : ar_len_q;
        ld_size  = ld_fresh ? axifull_ARSIZE  : ar_size_q;
        ld_burst = ld_fresh ? axifull_ARBURST : ar_burst_q;
        ld_last  = ld_fresh ? (axifull_ARLEN == 8'd0) : (r_cnt_q == ar_len_q);
        ld_bad   = burst_bad(ld_len, ld_size, ld_burst) || out_of_range(ld_addr);
        ld_data  = ld_bad ? '0 : mem_rd[ld_addr[BYTE_SH +: IDX_W]];

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axifull_ARVALID && arready_q) begin
                    ar_len_d   = axifull_ARLEN;
                    ar_size_d  = axifull_ARSIZE;
                    ar_burst_d = axifull_ARBURST;
                    ar_addr_d  = next_addr(ld_addr, ld_len, ld_size, ld_burst);
                    r_cnt_d    = 8'd1;
                    rid_d      = axifull_ARID;
                    rvalid_d   = 1'b1;
                    rdata_d    = ld_data;
                    rresp_d    = ld_bad ? RESP_SLVERR : RESP_OKAY;
                    rlast_d    = ld_last;
                    arready_d  = 1'b0;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && axifull_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d   = ld_data;
                        rresp_d   = ld_bad ? RESP_SLVERR : RESP_OKAY;
                        rlast_d   = ld_last;
                        ar_addr_d = next_addr(ld_addr, ld_len, ld_size, ld_burst);
                        r_cnt_d   = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign axifull_AWREADY = awready_q;
    assign axifull_WREADY  = wready_q;
    assign axifull_BVALID  = bvalid_q;
    assign axifull_BID     = bid_q;
    assign axifull_BRESP   = bresp_q;
    assign axifull_ARREADY = arready_q;
    assign axifull_RVALID  = rvalid_q;
    assign axifull_RID     = rid_q;
    assign axifull_RDATA   = rdata_q;
    assign axifull_RRESP   = rresp_q;
    assign axifull_RLAST   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_full_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_full_mem_slave
// Brief   : Directed scoreboard bench for axi_full_mem_slave.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_full_mem_slave;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 1;
    localparam int DEPTH  = 1024;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [7:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [7:0]        wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [7:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    always #5 clk = ~clk;

    axi_full_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .INIT_INDEX(1)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .axifull_AWID(awid), .axifull_AWADDR(awaddr), .axifull_AWLEN(awlen),
        .axifull_AWSIZE(awsize), .axifull_AWBURST(awburst), .axifull_AWVALID(awvalid),
        .axifull_AWREADY(awready),
        .axifull_WDATA(wdata), .axifull_WSTRB(wstrb), .axifull_WLAST(wlast),
        .axifull_WVALID(wvalid), .axifull_WREADY(wready),
        .axifull_BID(bid), .axifull_BRESP(bresp), .axifull_BVALID(bvalid), .axifull_BREADY(bready),
        .axifull_ARID(arid), .axifull_ARADDR(araddr), .axifull_ARLEN(arlen),
        .axifull_ARSIZE(arsize), .axifull_ARBURST(arburst), .axifull_ARVALID(arvalid),
        .axifull_ARREADY(arready),
        .axifull_RID(rid), .axifull_RDATA(rdata), .axifull_RRESP(rresp), .axifull_RLAST(rlast),
        .axifull_RVALID(rvalid), .axifull_RREADY(rready)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   id;
    } r_exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     bp_en    = 1'b0;
    bit     gap_watch = 1'b0;
    int     gaps     = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within bound, expected one", name);
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast});
    endfunction

    // R monitor: compare at the handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (gap_watch && !rvalid) gaps++;
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_unexpected: got beat %0h, expected none", rdata);
            end else begin
                r_exp_t e;
                e = rq.pop_front();
                check("r_beat", 128'({rid, rresp, rlast, rdata}), 128'({e.id, e.resp, e.last, e.data}));
            end
        end
    end

    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got bresp %0h, expected none", bresp);
            end else begin
                b_exp_t e;
                e = bq.pop_front();
                check("b_resp", 128'({bid, bresp}), 128'({e.id, e.resp}));
            end
        end
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_r(input logic [DATA_W-1:0] d, input logic [1:0] resp,
                          input logic last, input logic [ID_W-1:0] id);
        r_exp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    // which: 0 = AWREADY, 1 = WREADY, 2 = ARREADY
    task automatic wait_ready(input int which, input string name);
        int  t;
        logic rdy;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            rdy = (which == 0) ? awready : (which == 1) ? wready : arready;
        end while (!rdy && t < 100);
        if (!rdy) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wait_ready(2, "ar_timeout");
        arvalid = 1'b0;
    endtask

    task automatic wait_r_drain();
        int t;
        t = 0;
        while (rq.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (rq.size() != 0) begin
            timeout("r_drain_timeout");
            rq.delete();
        end
        #1;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [DATA_W-1:0] base, input logic [7:0] strb,
                            input int nbeats, input int bdelay);
        int t;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        wait_ready(0, "aw_timeout");
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata  = base + DATA_W'(i);
            wstrb  = strb;
            wlast  = (i == nbeats - 1);
            wvalid = 1'b1;
            wait_ready(1, "w_timeout");
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge clk);
            #1;
            check("b_held_while_bready_low", 128'(bvalid), 128'(1));
        end
        bready = 1'b1;
        t = 0;
        while (bq.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (bq.size() != 0) begin
            timeout("b_timeout");
            bq.delete();
        end
        #1;
        bready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and first edge after release
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 128'({awready, arready}), 128'(2'b11));

        // 1: INCR read of words 0..7, back to back
        for (int k = 0; k < 8; k++) push_r(DATA_W'(k), OKAY, (k == 7), 1'b1);
        do_ar(1'b1, 32'h0, 8'd7, 3'd3, INCR);
        gaps = 0;
        gap_watch = 1'b1;
        wait_r_drain();
        gap_watch = 1'b0;
        check("t1_back_to_back_gaps", 128'(gaps), 128'(0));

        // 2: INCR write, delayed BREADY, read-back with random RREADY
        push_b(1'b0, OKAY);
        do_write(1'b0, 32'h100, 8'd3, INCR, 64'hA0, 8'hFF, 4, 3);
        bp_en = 1'b1;
        for (int k = 0; k < 4; k++) push_r(64'hA0 + DATA_W'(k), OKAY, (k == 3), 1'b0);
        do_ar(1'b0, 32'h100, 8'd3, 3'd3, INCR);
        wait_r_drain();
        bp_en = 1'b0;

        // 3: partial strobe over word 40
        push_b(1'b0, OKAY);
        do_write(1'b0, 32'h140, 8'd0, INCR, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1, 0);
        push_r(64'h0000_0000_FFFF_FFFF, OKAY, 1'b1, 1'b1);
        do_ar(1'b1, 32'h140, 8'd0, 3'd3, INCR);
        wait_r_drain();

        // 4: WRAP 3,0,1,2 and FIXED word 4 four times
        push_r(64'd3, OKAY, 1'b0, 1'b0);
        push_r(64'd0, OKAY, 1'b0, 1'b0);
        push_r(64'd1, OKAY, 1'b0, 1'b0);
        push_r(64'd2, OKAY, 1'b1, 1'b0);
        do_ar(1'b0, 32'h18, 8'd3, 3'd3, WRAP);
        wait_r_drain();
        for (int k = 0; k < 4; k++) push_r(64'd4, OKAY, (k == 3), 1'b1);
        do_ar(1'b1, 32'h20, 8'd3, 3'd3, FIXED);
        wait_r_drain();

        // 5: burst crossing the top of memory
        push_r(64'd1022, OKAY, 1'b0, 1'b0);
        push_r(64'd1023, OKAY, 1'b0, 1'b0);
        push_r(64'd0, SLVERR, 1'b0, 1'b0);
        push_r(64'd0, SLVERR, 1'b1, 1'b0);
        do_ar(1'b0, 32'h1FF0, 8'd3, 3'd3, INCR);
        wait_r_drain();
        push_b(1'b1, SLVERR);
        do_write(1'b1, 32'h1FF0, 8'd3, INCR, 64'hC0, 8'hFF, 4, 0);
        push_r(64'd0, OKAY, 1'b0, 1'b0);
        push_r(64'd1, OKAY, 1'b1, 1'b0);
        do_ar(1'b0, 32'h0, 8'd1, 3'd3, INCR);
        wait_r_drain();
        push_r(64'hC0, OKAY, 1'b0, 1'b0);
        push_r(64'hC1, OKAY, 1'b1, 1'b0);
        do_ar(1'b0, 32'h1FF0, 8'd1, 3'd3, INCR);
        wait_r_drain();

        // Malformed: WRAP with LEN 2, and SIZE wider than the bus
        for (int k = 0; k < 3; k++) push_r(64'd0, SLVERR, (k == 2), 1'b1);
        do_ar(1'b1, 32'h0, 8'd2, 3'd3, WRAP);
        wait_r_drain();
        push_r(64'd0, SLVERR, 1'b1, 1'b0);
        do_ar(1'b0, 32'h8, 8'd0, 3'd4, INCR);
        wait_r_drain();

        // Narrow 4-byte INCR beats: words 2,2,3,3
        push_r(64'd2, OKAY, 1'b0, 1'b1);
        push_r(64'd2, OKAY, 1'b0, 1'b1);
        push_r(64'd3, OKAY, 1'b0, 1'b1);
        push_r(64'd3, OKAY, 1'b1, 1'b1);
        do_ar(1'b1, 32'h10, 8'd3, 3'd2, INCR);
        wait_r_drain();

        // Early WLAST, then extra beats past LEN
        push_b(1'b0, SLVERR);
        do_write(1'b0, 32'h300, 8'd3, INCR, 64'hD0, 8'hFF, 2, 0);
        push_b(1'b1, SLVERR);
        do_write(1'b1, 32'h340, 8'd1, INCR, 64'hE0, 8'hFF, 3, 0);
        push_r(64'hE0, OKAY, 1'b0, 1'b0);
        push_r(64'hE1, OKAY, 1'b0, 1'b0);
        push_r(64'h6A, OKAY, 1'b1, 1'b0);
        do_ar(1'b0, 32'h340, 8'd2, 3'd3, INCR);
        wait_r_drain();

        // 6: asynchronous reset during beat 2 of a 4-beat write
        awid = 1'b0; awaddr = 32'h200; awlen = 8'd3; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
        wait_ready(0, "t6_aw_timeout");
        awvalid = 1'b0;
        wdata = 64'hB0; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        wait_ready(1, "t6_w_timeout");
        wdata = 64'hB1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", out_vec(), 128'(0));
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_after_release", 128'({awready, arready, wready, bvalid}), 128'(4'b1100));
        push_r(64'hB0, OKAY, 1'b0, 1'b1);
        push_r(64'h41, OKAY, 1'b0, 1'b1);
        push_r(64'h42, OKAY, 1'b0, 1'b1);
        push_r(64'h43, OKAY, 1'b1, 1'b1);
        do_ar(1'b1, 32'h200, 8'd3, 3'd3, INCR);
        wait_r_drain();
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_bvalid", 128'(bvalid), 128'(0));

        check("queues_empty", 128'(rq.size() + bq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_full_mem_slave.md
Name: axi_full_mem_slave

Overview:
Synthesisable, parametrised AXI4-full slave memory that stands in for external DDR behind the AXI-full master in the top-level test system.
Generalises the fixed 64-bit, 1024-word, INCR-only slave model:
- configurable data, address and ID widths and depth;
- FIXED, INCR and WRAP bursts with AxSIZE stepping;
- WSTRB byte enables;
- ID echo;
- SLVERR for out-of-range or malformed bursts.
Read and write paths are independent; each allows one outstanding transaction.

Parameters:
DATA_W, 64, data bus width in bits (32/64/128).
ADDR_W, 32, byte-address width.
ID_W, 1, AXI ID width.
DEPTH, 1024, memory depth in DATA_W words.
INIT_INDEX, 1, if 1 mem[i]=i at time zero; if 0 contents are X.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
axifull_AWID  in  ID_W  write ID
axifull_AWADDR  in  ADDR_W  write start byte address
axifull_AWLEN  in  8  beats-1
axifull_AWSIZE  in  3  log2 bytes per beat
axifull_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
axifull_AWVALID  in  1  address valid
axifull_AWREADY  out  1  address ready
axifull_WDATA  in  DATA_W  write data
axifull_WSTRB  in  DATA_W/8  byte enables
axifull_WLAST  in  1  last beat
axifull_WVALID  in  1  data valid
axifull_WREADY  out  1  data ready
axifull_BID  out  ID_W  echoed AWID
axifull_BRESP  out  2  00 OKAY, 10 SLVERR
axifull_BVALID  out  1  response valid
axifull_BREADY  in  1  response ready
axifull_ARID, axifull_ARADDR, axifull_ARLEN, axifull_ARSIZE, axifull_ARBURST  in  ID_W/ADDR_W/8/3/2  read request fields, same encodings as AW
axifull_ARVALID  in  1  read address valid
axifull_ARREADY  out  1  read address ready
axifull_RID  out  ID_W  echoed ARID
axifull_RDATA  out  DATA_W  read data
axifull_RRESP  out  2  per-beat response
axifull_RLAST  out  1  last read beat
axifull_RVALID  out  1  read valid
axifull_RREADY  in  1  read ready

Behaviour:

Reset:
- All outputs are 0 on reset, including the READYs.
- Both FSMs go to IDLE and any burst in progress is abandoned with no response.
- Memory contents are not reset.

Addressing:
- Word index = beat address >> log2(DATA_W/8).
- A beat is out of range when index >= DEPTH.
- Next beat address:
  - FIXED: unchanged.
  - INCR: (addr & ~(2^SIZE-1)) + 2^SIZE.
  - WRAP: same as INCR, but wrapped within a container of (LEN+1)*2^SIZE bytes, aligned to that size.
- AxSIZE > log2(DATA_W/8), or WRAP with LEN not in {1,3,7,15}: the whole burst is malformed.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/size/burst, clear the beat count and error flag, then go to W_DATA with AWREADY=0 and WREADY=1 on the next cycle.
- W_DATA: each W handshake writes the bytes where WSTRB=1 to mem[index] in the same edge, then advances the address and the count.
- Malformed burst or out-of-range beat: the data is dropped and the error flag is set.
- Extra beats beyond LEN+1 without WLAST: accepted, dropped, error flag set.
- WLAST on beat count != LEN: error flag set.
- On the WLAST handshake: WREADY=0, go to W_RESP with BVALID=1, BID=latched ID, BRESP=10 if the error flag is set, else 00.
- W_RESP: hold until BREADY, then go to W_IDLE (AWREADY=1 the following cycle).
- WVALID while in W_IDLE is not accepted (WREADY=0).

Read FSM (R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On AR handshake, latch the fields. The next cycle has RVALID=1 with the first beat registered.
- RDATA = mem[index] sampled at load time. Out-of-range or malformed beats give RDATA=0 and RRESP=10.
- RLAST=1 exactly on beat LEN.
- On R handshake: load the next beat in the next cycle (back-to-back, one beat per cycle when RREADY is held high).
- On the RLAST handshake: RVALID=0 and return to R_IDLE.
- RVALID/RDATA/RLAST hold stable while RREADY=0.

Simultaneous events:
- AW and AR handshakes in the same cycle are both accepted.
- A read beat loaded in the same edge as a write to the same word returns the pre-write data.

Test Plan:
1. INIT_INDEX=1. AR addr 0x0, LEN 7, SIZE 3, INCR, RREADY=1 → 8 beats on consecutive cycles, data 0..7, RLAST on beat 8, RRESP 00, RID=ARID.
2. AW addr 0x100, LEN 3, INCR; WDATA A0..A3, WSTRB 0xFF; BREADY delayed 3 cycles → BVALID held, BRESP 00. Read-back of words 32..35 = A0..A3.
3. Write word 40 with WSTRB 0x0F, data 0xFFFF_FFFF_FFFF_FFFF, over old value 40 → reads 0x0000_0000_FFFF_FFFF.
4. WRAP, addr 0x18, LEN 3, SIZE 3, read → word order 3,0,1,2. FIXED LEN 3 at 0x20 → word 4 returned four times.
5. Read at addr (DEPTH-2)*8, LEN 3 → beats 1–2 OKAY with data; beats 3–4 RDATA 0, RRESP 10. Write of the same burst → BRESP 10, and words 0..1 unchanged.
6. Deassert ARESETn during write beat 2 of 4 → all outputs 0 asynchronously. After release, AWREADY=1 and ARREADY=1 on the first edge; beat 1 data retained in memory, no BVALID issued.
